// File: rtl/serial_compare.sv
// Multi-cycle magnitude comparator: scans two operands most-significant digit
// first, DIGIT bits per cycle, and stops on the first digit that differs.
module serial_compare #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            signedMode,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic                            busy,
    output logic                            done,
    output logic                            aGtB,
    output logic                            aEqB,
    output logic                            aLtB,
    output logic [$clog2(WIDTH/DIGIT):0]    cycles
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [DIGIT-1:0] in_da;
    logic [DIGIT-1:0] in_db;
    logic [DIGIT-1:0] sc_da;
    logic [DIGIT-1:0] sc_db;
    logic             sign_split;

    // Digit j counts from the most significant end.
    function automatic logic [DIGIT-1:0] digit_of(input logic [WIDTH-1:0] x,
                                                  input logic [IW-1:0]    j);
        digit_of = DIGIT'(x >> (DIGIT * (N - 1 - 32'(j))));
    endfunction

    // Differing signs decide a signed compare outright; with equal signs the
    // unsigned digit scan gives the right two's-complement ordering.
    assign sign_split = signedMode & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign in_da      = digit_of(a, IW'(0));
    assign in_db      = digit_of(b, IW'(0));
    assign sc_da      = digit_of(a_q, idx);
    assign sc_db      = digit_of(b_q, idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            aGtB   <= 1'b0;
            aEqB   <= 1'b0;
            aLtB   <= 1'b0;
            cycles <= '0;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (sign_split) begin
                            done   <= 1'b1;
                            aGtB   <= ~a[WIDTH-1];
                            aEqB   <= 1'b0;
                            aLtB   <= ~b[WIDTH-1];
                            cycles <= CW'(1);
                        end else if (in_da != in_db) begin
                            done   <= 1'b1;
                            aGtB   <= (in_da > in_db);
                            aEqB   <= 1'b0;
                            aLtB   <= (in_da < in_db);
                            cycles <= CW'(1);
                        end else if (N == 1) begin
                            done   <= 1'b1;
                            aGtB   <= 1'b0;
                            aEqB   <= 1'b1;
                            aLtB   <= 1'b0;
                            cycles <= CW'(1);
                        end else begin
                            a_q   <= a;
                            b_q   <= b;
                            idx   <= IW'(1);
                            state <= SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (sc_da != sc_db) begin
                        done   <= 1'b1;
                        aGtB   <= (sc_da > sc_db);
                        aEqB   <= 1'b0;
                        aLtB   <= (sc_da < sc_db);
                        cycles <= CW'(idx) + CW'(1);
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else if (idx == IW'(N - 1)) begin
                        done   <= 1'b1;
                        aGtB   <= 1'b0;
                        aEqB   <= 1'b1;
                        aLtB   <= 1'b0;
                        cycles <= CW'(N);
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare.sv
// Scoreboard bench for serial_compare at WIDTH=8, DIGIT=2.
module tb_serial_compare;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIGIT = 2;
    localparam int unsigned N     = WIDTH / DIGIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] cycles;

    typedef struct packed {
        logic       gt;
        logic       eq;
        logic       lt;
        logic [2:0] cyc;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signedMode (signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .aGtB       (gt),
        .aEqB       (eq),
        .aLtB       (lt),
        .cycles     (cycles)
    );

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
        res_t r;
        r.gt  = s ? ($signed(x) > $signed(y)) : (x > y);
        r.lt  = s ? ($signed(x) < $signed(y)) : (x < y);
        r.eq  = (x == y);
        r.cyc = 3'(N);
        if (s && (x[7] != y[7])) begin
            r.cyc = 3'd1;
        end else begin
            for (int j = N - 1; j >= 0; j--) begin
                if (x[7-2*j -: 2] != y[7-2*j -: 2]) r.cyc = 3'(j + 1);
            end
        end
        return r;
    endfunction

    // Every done pulse retires exactly one expected result.
    res_t mon_e;
    always @(negedge clk) begin
        if (!rst && done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done=1 with no compare outstanding at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({gt, eq, lt, cycles} !== mon_e) begin
                    bad++;
                    $display("FAIL result: got gt/eq/lt=%b%b%b cycles=%0d expected %b%b%b cycles=%0d at %0t",
                             gt, eq, lt, cycles, mon_e.gt, mon_e.eq, mon_e.lt, mon_e.cyc, $time);
                end
            end
            total++;
            if ($countones({gt, eq, lt}) != 1) begin
                bad++;
                $display("FAIL onehot: got gt/eq/lt=%b%b%b expected exactly one set", gt, eq, lt);
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1 with start released.
    task automatic drive_start(input logic [7:0] x, input logic [7:0] y, input logic s,
                               input bit accepted);
        start       = 1'b1;
        a           = x;
        b           = y;
        signed_mode = s;
        if (accepted) exp_q.push_back(model(x, y, s));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < 30 && (exp_q.size() != 0 || busy)) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL %s_timeout: outstanding=%0d busy=%b expected drained", tag, exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_width: got done=%b expected 0 one cycle after pulse", tag, done);
        end
    endtask

    task automatic test_reset;
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, gt, eq, lt, cycles} !== 8'h00) begin
            bad++;
            $display("FAIL reset_init: got %b expected 00000000", {busy, done, gt, eq, lt, cycles});
        end
        @(posedge clk); #1; rst = 1'b0;
        drive_start(8'hF8, 8'h05, 1'b0, 1'b1);
        wait_idle("reset_pre");
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, gt, eq, lt, cycles} !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle: got %b expected 00000000", {busy, done, gt, eq, lt, cycles});
        end
        @(posedge clk); #1; rst = 1'b0;
        drive_start(8'h5A, 8'h5B, 1'b0, 1'b0);
        @(posedge clk); #3; rst = 1'b1;
        #1;
        total++;
        if ({busy, done, gt, eq, lt, cycles} !== 8'h00) begin
            bad++;
            $display("FAIL reset_scan: got %b expected 00000000", {busy, done, gt, eq, lt, cycles});
        end
        @(posedge clk); #1; rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        total++;
        if (dcnt != 0 || busy !== 1'b0 || cycles !== 3'd0) begin
            bad++;
            $display("FAIL reset_abort: got done_count=%0d busy=%b cycles=%0d expected 0 0 0", dcnt, busy, cycles);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sign_split;
        for (int m = 1; m >= 0; m--) begin
            drive_start(8'hF8, 8'h05, 1'(m), 1'b1);
            @(negedge clk);
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL sign_split_m%0d: got done=%b busy=%b expected done=1 busy=0", m, done, busy);
            end
            @(posedge clk); #1;
            wait_idle("sign_split");
        end
    endtask

    task automatic test_scan;
        int k  = 0;
        int nb = 0;
        drive_start(8'h5A, 8'h5B, 1'b0, 1'b1);
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (done) break;
            if (busy) nb++;
            a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
        end
        total++;
        if (k != 4 || nb != 3) begin
            bad++;
            $display("FAIL scan_latency: got done_cycle=%0d busy_cycles=%0d expected 4 and 3", k, nb);
        end
        @(posedge clk); #1;
        wait_idle("scan");
    endtask

    task automatic test_signed_same;
        drive_start(8'hFD, 8'hFB, 1'b1, 1'b1);
        wait_idle("signed_same");
        drive_start(8'hA5, 8'hA5, 1'b0, 1'b1);
        wait_idle("equal");
        total++;
        if ({gt, eq, lt, cycles} !== {3'b010, 3'd4}) begin
            bad++;
            $display("FAIL equal_hold: got %b%b%b cycles=%0d expected 010 cycles=4", gt, eq, lt, cycles);
        end
    endtask

    task automatic test_busy_ignore;
        drive_start(8'h5A, 8'h5B, 1'b0, 1'b1);
        start = 1'b1; a = 8'h00; b = 8'hFF; signed_mode = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({done, busy, gt, eq, lt, cycles} !== {5'b10001, 3'd4}) begin
            bad++;
            $display("FAIL busy_ignore: got done=%b busy=%b flags=%b%b%b cycles=%0d expected 1 0 001 4",
                     done, busy, gt, eq, lt, cycles);
        end
        drive_start(8'h80, 8'h10, 1'b0, 1'b1);
        wait_idle("done_cycle_start");
    endtask

    task automatic test_back_to_back;
        logic [7:0] xs [4] = '{8'hC0, 8'h10, 8'h80, 8'h7F};
        logic [7:0] ys [4] = '{8'h10, 8'hC0, 8'h7F, 8'h80};
        logic       ss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_start(xs[i], ys[i], ss[i], 1'b1);
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back_%0d: got done=%b busy=%b expected 1 0", i, done, busy);
            end
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_random;
        logic [7:0] x;
        logic [7:0] y;
        for (int i = 0; i < 300; i++) begin
            x = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ 8'(1 << $urandom_range(0, 3));
                2:       y = x ^ 8'(1 << $urandom_range(0, 5));
                default: y = 8'($urandom);
            endcase
            drive_start(x, y, 1'($urandom), 1'b1);
            wait_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_sign_split();
        test_scan();
        test_signed_same();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d outstanding results expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_compare.md
Name: serial_compare

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the team's 4-bit combinational signed comparator.
- Compares two WIDTH-bit operands most-significant digit first, DIGIT bits per cycle, and terminates early on the first differing digit.
- Supports signed (two's complement) and unsigned modes, selectable per operation.
- Sits beside the datapath where wide compares would break timing. Uses a start/busy/done handshake and reports the cycles taken.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle; must divide WIDTH exactly.
- N (derived, not overridable): WIDTH/DIGIT, the number of digits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on a rising edge only while busy=0.
- signedMode  input  1  1 = two's complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an accepted compare is still scanning.
- done  output  1  one-cycle pulse when a result is written.
- aGtB  output  1  registered result: A greater than B.
- aEqB  output  1  registered result: A equal to B.
- aLtB  output  1  registered result: A less than B.
- cycles  output  clog2(N)+1  latency of the last completed compare.

Behaviour:
- Reset (async, immediate): state=IDLE. busy, done, aGtB, aEqB, aLtB and cycles all 0. The captured operands are cleared.
- Digit j (j = 0..N-1) is bits [WIDTH-1-j*DIGIT -: DIGIT]; j=0 is the most significant digit.
- FSM states: IDLE, SCAN.
- IDLE, start=1, evaluated combinationally from the inputs at the sampling edge:
  - signedMode=1 and a[WIDTH-1]≠b[WIDTH-1]: decide immediately. aGtB = ~a[MSB], aLtB = ~b[MSB], aEqB = 0. cycles=1. State stays IDLE.
  - Otherwise compare digit 0 unsigned. If it differs: decide GT or LT, cycles=1, stay IDLE.
  - Otherwise capture a, b and mode, set index=1, and go to SCAN.
  - When N=1 and digit 0 is equal, decide EQ with cycles=1.
- Same-sign signed compares use the unsigned digit scan; this is correct for two's complement.
- SCAN, each edge: compare digit index unsigned.
  - Differ: decide GT or LT, cycles=index+1, go to IDLE.
  - Equal and index=N-1: decide EQ, cycles=N, go to IDLE.
  - Otherwise index+1.
- Decide edge:
  - Exactly one of aGtB/aEqB/aLtB is written to 1; the other two are written to 0.
  - cycles is written with the latency.
  - done=1 for the following cycle only.
- Results and cycles hold their values until the next decide edge. Accepting a new start does not clear them.
- busy = (state==SCAN). Register busy or derive it from state; it must never glitch high in IDLE.
- Latency from the start-sampling edge to the done cycle: 1 when the sign differs or digit 0 decides, j+1 when digit j decides, N when equal.
- start while busy=1 is ignored: no capture and no effect on the current scan.
- start in the cycle where done=1 (state IDLE) is accepted normally. Back-to-back throughput for 1-cycle compares is one per cycle.
- Changes to a, b or signedMode during SCAN have no effect, because the captured copies are used.
- rst during SCAN aborts the compare: no done pulse, and all outputs return to 0.

Test Plan (WIDTH=8, DIGIT=2, N=4):
1. Assert rst mid-idle and mid-SCAN (start a=0x5A, b=0x5B; rst after 2 cycles) -> busy=0, done never pulses, aGtB/aEqB/aLtB=0, cycles=0.
2. signedMode=1, a=0xF8 (-8), b=0x05 -> done next cycle, aLtB=1, cycles=1, busy never high. Repeat with signedMode=0 -> aGtB=1, cycles=1.
3. signedMode=0, a=0x5A, b=0x5B -> busy for 3 cycles, done on the 4th cycle, aLtB=1, cycles=4. Toggle a/b during busy -> same result.
4. signedMode=1, a=0xFD (-3), b=0xFB (-5) -> aGtB=1, cycles=3. Then a=b=0xA5 unsigned -> aEqB=1, cycles=4.
5. During test 3's scan, pulse start with a=0x00, b=0xFF -> ignored, result unchanged. In the done cycle, start a=0x80, b=0x10 unsigned -> accepted, next cycle aGtB=1, cycles=1.
6. Random sweep of a, b and signedMode against a reference model: exactly one result flag set, result matches a signed/unsigned compare, cycles equals first-differing-digit index+1 (or 4 when equal), done is always a single-cycle pulse.
